// File: rtl/memoria_notas_prog_if.sv
// Bus bundle for the programmable note-pattern memory: playback control,
// pattern/length write port and the registered playback outputs.
interface memoria_notas_prog_if #(
  parameter int NUM_NOTAS = 7,
  parameter int SEL_W     = 3,
  parameter int ADDR_W    = 4
);
  logic [SEL_W-1:0]     select_musica;
  logic                 iniciar;
  logic                 parar;
  logic                 modo_loop;
  logic                 tick;
  logic                 wr_en;
  logic [SEL_W-1:0]     wr_musica;
  logic [ADDR_W-1:0]    wr_passo;
  logic [NUM_NOTAS-1:0] wr_dado;
  logic                 wr_len_en;
  logic [ADDR_W:0]      wr_len;
  logic [NUM_NOTAS-1:0] data_out;
  logic [ADDR_W-1:0]    passo_atual;
  logic                 tocando;
  logic                 fim_musica;

  // Controller / testbench side
  modport master (
    output select_musica, iniciar, parar, modo_loop, tick,
    output wr_en, wr_musica, wr_passo, wr_dado, wr_len_en, wr_len,
    input  data_out, passo_atual, tocando, fim_musica
  );

  // Memory / sequencer side
  modport slave (
    input  select_musica, iniciar, parar, modo_loop, tick,
    input  wr_en, wr_musica, wr_passo, wr_dado, wr_len_en, wr_len,
    output data_out, passo_atual, tocando, fim_musica
  );
endinterface

// File: rtl/memoria_notas_prog.sv
// Programmable note-pattern RAM with playback sequencer. Songs are stored
// as PASSOS consecutive words; the song index forms the upper address bits.
// The read address is chosen combinationally from the next step, so a tick
// updates passo_atual and data_out on the same edge.
module memoria_notas_prog #(
  parameter int NUM_NOTAS   = 7,
  parameter int NUM_MUSICAS = 8,
  parameter int PASSOS      = 16,
  parameter int SEL_W       = 3,
  parameter int ADDR_W      = 4
) (
  input  logic clock,
  input  logic reset,
  memoria_notas_prog_if.slave bus
);

  localparam int              DEPTH   = NUM_MUSICAS * PASSOS;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(PASSOS);

  typedef enum logic {OCIOSO, TOCANDO} estado_t;

  estado_t              estado;
  logic [NUM_NOTAS-1:0] mem [DEPTH];
  logic [ADDR_W:0]      len_reg [NUM_MUSICAS];
  logic [SEL_W-1:0]     musica_ativa;
  logic [ADDR_W-1:0]    passo_reg;
  logic [NUM_NOTAS-1:0] data_reg;
  logic                 tocando_reg;
  logic                 fim_reg;

  logic [ADDR_W:0]          passo_inc;
  logic                     fim_passo;
  logic                     avanca;
  logic [SEL_W+ADDR_W-1:0]  rd_addr;
  logic [ADDR_W:0]          len_clamp;

  // End of song when the next step would reach the stored length. Using >=
  // means a length shrunk below the current step ends on the next tick.
  assign passo_inc = {1'b0, passo_reg} + 1'b1;
  assign fim_passo = (passo_inc >= len_reg[musica_ativa]);
  assign avanca    = (estado == TOCANDO) && bus.tick;

  // Select the RAM word that becomes data_out on the coming edge
  always_comb begin
    rd_addr = {musica_ativa, passo_inc[ADDR_W-1:0]};
    if (bus.iniciar) begin
      rd_addr = {bus.select_musica, {ADDR_W{1'b0}}};
    end else if (fim_passo) begin
      rd_addr = {musica_ativa, {ADDR_W{1'b0}}};
    end
  end

  // Clamp requested song length into 1..PASSOS
  always_comb begin
    len_clamp = bus.wr_len;
    if (bus.wr_len == '0) begin
      len_clamp = (ADDR_W + 1)'(1);
    end else if (bus.wr_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
  end

  // Pattern RAM write port; no reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (bus.wr_en) begin
      mem[{bus.wr_musica, bus.wr_passo}] <= bus.wr_dado;
    end
  end

  // Per-song length registers, full length after reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MUSICAS; i++) begin
        len_reg[i] <= LEN_MAX;
      end
    end else if (bus.wr_len_en) begin
      for (int i = 0; i < NUM_MUSICAS; i++) begin
        if (bus.wr_musica == SEL_W'(i)) begin
          len_reg[i] <= len_clamp;
        end
      end
    end
  end

  // Playback FSM: parar beats iniciar beats tick; all outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      musica_ativa <= '0;
      passo_reg    <= '0;
      data_reg     <= '0;
      tocando_reg  <= 1'b0;
      fim_reg      <= 1'b0;
    end else begin
      fim_reg <= 1'b0;
      if (bus.parar) begin
        estado      <= OCIOSO;
        passo_reg   <= '0;
        data_reg    <= '0;
        tocando_reg <= 1'b0;
      end else if (bus.iniciar) begin
        musica_ativa <= bus.select_musica;
        estado       <= TOCANDO;
        passo_reg    <= '0;
        data_reg     <= mem[rd_addr];
        tocando_reg  <= 1'b1;
      end else if (avanca) begin
        if (fim_passo) begin
          fim_reg   <= 1'b1;
          passo_reg <= '0;
          if (bus.modo_loop) begin
            data_reg <= mem[rd_addr];
          end else begin
            estado      <= OCIOSO;
            data_reg    <= '0;
            tocando_reg <= 1'b0;
          end
        end else begin
          passo_reg <= passo_inc[ADDR_W-1:0];
          data_reg  <= mem[rd_addr];
        end
      end
    end
  end

  assign bus.data_out    = data_reg;
  assign bus.passo_atual = passo_reg;
  assign bus.tocando     = tocando_reg;
  assign bus.fim_musica  = fim_reg;

endmodule

// File: tb/tb_memoria_notas_prog.sv
// Directed bench for memoria_notas_prog: a table of single-cycle vectors
// for the main playback paths plus hand-written multi-cycle sequences.
module tb_memoria_notas_prog;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  memoria_notas_prog_if bus ();

  memoria_notas_prog dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Hard stop in case something never returns
  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ini, par, tk, lp;
    logic [2:0] sel;
    logic [6:0] d;
    logic [3:0] p;
    logic       toc, fim;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ini, par, tk, lp, input logic [2:0] sel,
                              input logic [6:0] d, input logic [3:0] p,
                              input logic toc, fim);
    vec_t v;
    v.ini = ini; v.par = par; v.tk = tk; v.lp = lp; v.sel = sel;
    v.d = d; v.p = p; v.toc = toc; v.fim = fim;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [6:0] d, input logic [3:0] p,
                         input logic toc, input logic fim);
    chk({nm, ".data"}, 32'(bus.data_out), 32'(d));
    chk({nm, ".passo"}, 32'(bus.passo_atual), 32'(p));
    chk({nm, ".toc"}, 32'(bus.tocando), 32'(toc));
    chk({nm, ".fim"}, 32'(bus.fim_musica), 32'(fim));
  endtask

  task automatic step(input logic ini, par, tk, lp, input logic [2:0] sel);
    bus.iniciar = ini; bus.parar = par; bus.tick = tk;
    bus.modo_loop = lp; bus.select_musica = sel;
    @(posedge clock); #1;
    bus.iniciar = 1'b0; bus.parar = 1'b0; bus.tick = 1'b0;
  endtask

  task automatic wr(input logic [2:0] m, input logic [3:0] p, input logic [6:0] d);
    bus.wr_en = 1'b1; bus.wr_musica = m; bus.wr_passo = p; bus.wr_dado = d;
    @(posedge clock); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic lenw(input logic [2:0] m, input logic [4:0] l);
    bus.wr_len_en = 1'b1; bus.wr_musica = m; bus.wr_len = l;
    @(posedge clock); #1;
    bus.wr_len_en = 1'b0;
  endtask

  task automatic tick_n(input int n, input logic lp, output int fims);
    fims = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, lp, 3'd7);
      fims += int'(bus.fim_musica);
    end
  endtask

  initial begin
    int fims;
    bus.iniciar = 0; bus.parar = 0; bus.tick = 0; bus.modo_loop = 0;
    bus.select_musica = 0; bus.wr_en = 0; bus.wr_musica = 0; bus.wr_passo = 0;
    bus.wr_dado = 0; bus.wr_len_en = 0; bus.wr_len = 0;

    // ---- vector table ----
    // song 2 looping; select_musica driven to 7 while playing must be ignored
    vecs.push_back(mk(1, 0, 0, 1, 3'd2, 7'd1, 4'd0, 1, 0));
    for (int k = 1; k < 16; k++)
      vecs.push_back(mk(0, 0, 1, 1, 3'd7, 7'(1 << (k % 7)), 4'(k), 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3'd7, 7'd1, 4'd0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 3'd7, 7'd1, 4'd0, 1, 0));
    // song 5, length 4, one-shot
    vecs.push_back(mk(1, 0, 0, 0, 3'd5, 7'd16, 4'd0, 1, 0));
    for (int k = 1; k < 4; k++)
      vecs.push_back(mk(0, 0, 1, 0, 3'd5, 7'(16 + k), 4'(k), 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3'd5, 7'd0, 4'd0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 3'd5, 7'd0, 4'd0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3'd5, 7'd0, 4'd0, 0, 0));
    // parar+tick at step 6, then iniciar+tick
    vecs.push_back(mk(1, 0, 0, 1, 3'd2, 7'd1, 4'd0, 1, 0));
    for (int k = 1; k < 7; k++)
      vecs.push_back(mk(0, 0, 1, 1, 3'd7, 7'(1 << k), 4'(k), 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 3'd2, 7'd0, 4'd0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3'd2, 7'd1, 4'd0, 1, 0));

    // ---- reset ----
    #2 reset = 1'b0;
    #2;
    chk_out("reset", 7'd0, 4'd0, 0, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // ---- pattern load ----
    for (int i = 0; i < 16; i++) wr(3'd2, 4'(i), 7'(1 << (i % 7)));
    for (int i = 0; i < 16; i++) wr(3'd5, 4'(i), 7'(16 + i));
    lenw(3'd5, 5'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ini, vecs[i].par, vecs[i].tk, vecs[i].lp, vecs[i].sel);
      chk_out($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].toc, vecs[i].fim);
      $display("vec %0d: data=%b passo=%0d tocando=%0d fim=%0d", i,
               bus.data_out, bus.passo_atual, bus.tocando, bus.fim_musica);
    end

    // ---- read-before-write on a ticking step ----
    bus.wr_en = 1'b1; bus.wr_musica = 3'd2; bus.wr_passo = 4'd1; bus.wr_dado = 7'h55;
    step(0, 0, 1, 1, 3'd7);
    bus.wr_en = 1'b0;
    chk_out("rbw_old", 7'd2, 4'd1, 1, 0);
    tick_n(14, 1, fims);
    chk_out("rbw_s15", 7'd2, 4'd15, 1, 0);
    step(0, 0, 1, 1, 3'd7);
    chk_out("rbw_wrap", 7'd1, 4'd0, 1, 1);
    step(0, 0, 1, 1, 3'd7);
    chk_out("rbw_new", 7'h55, 4'd1, 1, 0);
    $display("rbw: data=%h passo=%0d", bus.data_out, bus.passo_atual);

    // ---- length shrunk below current step ----
    tick_n(4, 1, fims);
    chk_out("shr_s5", 7'd32, 4'd5, 1, 0);
    lenw(3'd2, 5'd3);
    chk_out("shr_hold", 7'd32, 4'd5, 1, 0);
    step(0, 0, 1, 1, 3'd7);
    chk_out("shr_end", 7'd1, 4'd0, 1, 1);
    step(0, 0, 1, 1, 3'd7);
    chk_out("shr_s1", 7'h55, 4'd1, 1, 0);
    step(0, 0, 1, 1, 3'd7);
    chk_out("shr_s2", 7'd4, 4'd2, 1, 0);
    step(0, 0, 1, 1, 3'd7);
    chk_out("shr_len3", 7'd1, 4'd0, 1, 1);
    $display("shrink: passo=%0d fim=%0d", bus.passo_atual, bus.fim_musica);

    // ---- asynchronous reset between edges ----
    #3 reset = 1'b0;
    #1;
    chk_out("areset", 7'd0, 4'd0, 0, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    step(1, 0, 0, 1, 3'd2);
    chk_out("ram_keep0", 7'd1, 4'd0, 1, 0);
    step(0, 0, 1, 1, 3'd7);
    chk_out("ram_keep1", 7'h55, 4'd1, 1, 0);
    step(0, 1, 0, 1, 3'd7);
    step(1, 0, 0, 0, 3'd5);
    chk_out("len16_start", 7'd16, 4'd0, 1, 0);
    tick_n(15, 0, fims);
    chk("len16_nofim", 32'(fims), 32'd0);
    chk_out("len16_s15", 7'd31, 4'd15, 1, 0);
    step(0, 0, 1, 0, 3'd7);
    chk_out("len16_end", 7'd0, 4'd0, 0, 1);
    $display("areset: len16 playback fims_before_end=%0d", fims);

    // ---- wr_len = 0 stored as 1 ----
    lenw(3'd5, 5'd0);
    step(1, 0, 0, 1, 3'd5);
    chk_out("len0_start", 7'd16, 4'd0, 1, 0);
    step(0, 0, 1, 1, 3'd7);
    chk_out("len0_t1", 7'd16, 4'd0, 1, 1);
    step(0, 0, 1, 1, 3'd7);
    chk_out("len0_t2", 7'd16, 4'd0, 1, 1);
    step(0, 0, 1, 0, 3'd7);
    chk_out("len0_once", 7'd0, 4'd0, 0, 1);
    $display("len0: tocando=%0d fim=%0d", bus.tocando, bus.fim_musica);

    // ---- wr_len = 31 stored as 16 ----
    lenw(3'd5, 5'd31);
    step(1, 0, 0, 0, 3'd5);
    tick_n(15, 0, fims);
    chk("len31_nofim", 32'(fims), 32'd0);
    chk_out("len31_s15", 7'd31, 4'd15, 1, 0);
    step(0, 0, 1, 0, 3'd7);
    chk_out("len31_end", 7'd0, 4'd0, 0, 1);
    $display("len31: passo=%0d fim=%0d", bus.passo_atual, bus.fim_musica);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memoria_notas_prog.md
Name: memoria_notas_prog

Overview:
Programmable note-pattern memory with a built-in playback sequencer: successor to the fixed 8-song × 16-step note ROM. Pattern RAM holds NUM_MUSICAS songs of PASSOS steps each, with a programmable length per song. Each entry is a NUM_NOTAS-bit note vector (one-hot note, all-zero = rest). It sits between the tempo/step generator (tick) and the tone generator / LED display (data_out), and a control FSM handles start, stop, loop and one-shot play.

Parameters:
NUM_NOTAS, 7, note vector width (data_out width)
NUM_MUSICAS, 8, number of songs; power of 2
PASSOS, 16, steps per song; power of 2
SEL_W, 3, log2(NUM_MUSICAS); song-select width
ADDR_W, 4, log2(PASSOS); step-index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
select_musica  in  SEL_W  song to play; sampled only when iniciar is accepted
iniciar  in  1  start/restart playback pulse
parar  in  1  stop playback pulse
modo_loop  in  1  1 = wrap at end of song; 0 = one-shot; sampled at each end-of-song
tick  in  1  one-cycle step-advance strobe from tempo generator
wr_en  in  1  pattern write strobe
wr_musica  in  SEL_W  write song index
wr_passo  in  ADDR_W  write step index
wr_dado  in  NUM_NOTAS  write note vector
wr_len_en  in  1  song-length write strobe (uses wr_musica)
wr_len  in  ADDR_W+1  song length, 1..PASSOS
data_out  out  NUM_NOTAS  current note vector, registered
passo_atual  out  ADDR_W  current step index, registered
tocando  out  1  high while playing
fim_musica  out  1  one-cycle pulse at end of song

Behaviour:
- Reset (async, reset=0): data_out=0, passo_atual=0, tocando=0, fim_musica=0, FSM=OCIOSO, all length registers=PASSOS. Pattern RAM is not cleared; contents are undefined until written.
- FSM states: OCIOSO, TOCANDO.
- Priority in each cycle: parar > iniciar > tick.
- parar, in any state: next edge goes to OCIOSO, with data_out=0, passo_atual=0, tocando=0. No fim_musica pulse.
- iniciar, in any state (restart allowed):
  - Latch select_musica into musica_ativa.
  - Next edge: TOCANDO, passo_atual=0, data_out=mem[select_musica][0], tocando=1.
  - A coincident tick is dropped.
- tick in OCIOSO: ignored.
- tick in TOCANDO, when passo_atual < len[musica_ativa]-1: passo_atual+1 and data_out=mem[musica_ativa][passo_atual+1], both on the same edge. Zero-latency step: RAM read uses the next-step address.
- tick in TOCANDO, when passo_atual = len-1 (end of song): fim_musica=1 for one cycle, then:
  - modo_loop=1: passo_atual=0, data_out=mem[musica_ativa][0], stay in TOCANDO.
  - modo_loop=0: go to OCIOSO, data_out=0, passo_atual=0, tocando=0.
- select_musica changes while playing are ignored until the next iniciar.
- Pattern writes (wr_en) are accepted in any state and take effect at the clock edge.
  - Read and write of the same location on the same edge: data_out gets the old data (read-before-write).
  - Writes to the active song affect later steps.
- Length writes (wr_len_en):
  - wr_len=0 is stored as 1; wr_len>PASSOS is stored as PASSOS.
  - A write that shrinks the active song below passo_atual+1 makes the next tick the end of song.
  - A write and an end-of-song decision on the same edge use the old length.
- wr_en and wr_len_en may be active together.
- data_out is not checked for one-hot; all-zero is a rest and is passed through.
- Length 1: every tick is an end of song (loop repeats step 0; one-shot ends on the first tick).

Test Plan:
- Write song 2, steps 0..15 = one-hot notes cycling 0000001..1000000; pulse iniciar with select_musica=2 and modo_loop=1 -> next edge data_out=0000001, passo_atual=0, tocando=1. 16 ticks -> fim_musica pulses on the 16th tick, and passo_atual wraps to 0 with data_out=mem[2][0].
- Set song 5 length to 4, one-shot (modo_loop=0), iniciar -> 3 ticks advance to step 3. The 4th tick gives fim_musica=1, tocando=0, data_out=0.
- In TOCANDO at step 6, assert parar and tick together -> OCIOSO, data_out=0, no fim_musica. Assert iniciar and tick together -> passo_atual=0, tick ignored.
- During play, write the active song at step passo_atual+1 on the same edge as a tick -> data_out shows the old value. Repeat in the next loop pass -> data_out shows the new value.
- Assert reset (reset=0) asynchronously mid-song, between clock edges -> outputs clear immediately. Length registers read back as 16 (full-length playback after iniciar). RAM contents are retained.
- Length-write boundaries: wr_len=0 -> every tick gives fim_musica. wr_len=31 -> the song plays 16 steps.
